is_array_ctrl: RTL and testbench
================================

Name: is_array_ctrl

Overview:
Sequencer for an ROWS x COLS input-stationary systolic array of MAC PEs.
- Preloads the stationary inputs by shifting them down the column chain, gated by the PE input_en pins.
- Streams K weight vectors through the array, driving a common process_en.
- Issues write strobes for the resulting partial-sum vectors.
- Sits between the local SRAM buffers (input, weight, psum) and the array, and reports busy/done to the layer-level controller.

Parameters:
ROWS, 4, array rows; input-chain depth.
COLS, 4, array columns (informational; skew is done in edge registers outside this block).
VEC_W, 8, width of num_vec; up to 2^VEC_W weight vectors per pass.
PSUM_LAT, 7, PROC-counter value at which the first valid psum vector is at the array output (>=1; default ROWS+COLS-1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  begin a pass; sampled only in IDLE.
num_vec  in  VEC_W  weight vector count minus 1 (K = num_vec+1); latched on start.
out_ready  in  1  psum sink can accept; low stalls the PROC phase.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse in DONE.
input_rd_en  out  1  input buffer read strobe.
input_rd_addr  out  clog2(ROWS)  input buffer address.
input_en  out  1  to all PE input_en pins.
weight_rd_en  out  1  weight buffer read strobe.
weight_rd_addr  out  VEC_W  weight vector index.
process_en  out  1  to all PE process_en pins.
psum_wr_en  out  1  psum buffer write strobe.
psum_wr_addr  out  VEC_W  psum vector index.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (also mid-pass): state goes to IDLE immediately. All outputs and counters go to 0. The latched K is cleared. No partial pass resumes.
- Buffer contract: both buffers have 1-cycle read latency. Read data holds while rd_en is low.
- States: IDLE, LOAD, PROC, DONE.
  - IDLE -> LOAD when start=1; num_vec is latched. start is ignored in all other states.
  - LOAD -> PROC after ROWS cycles.
  - PROC -> DONE after the counter p completes value PSUM_LAT+K-1.
  - DONE -> IDLE after 1 cycle.
- LOAD (counter i = 0..ROWS-1):
  - input_rd_en=1 and input_rd_addr=ROWS-1-i, so the deepest row is read first.
  - input_en is input_rd_en registered by one cycle. Its last pulse therefore lands in PROC p=0.
  - LOAD ignores out_ready.
- PROC (counter p = 0..PSUM_LAT+K-1):
  - p advances only in cycles with out_ready=1.
  - weight_rd_en = (p<K) & out_ready; weight_rd_addr = p.
  - process_en = (p>=1) & out_ready. At p=0 only the first weight read is issued, so it never overlaps input_en.
  - psum_wr_en = (PSUM_LAT <= p <= PSUM_LAT+K-1) & out_ready; psum_wr_addr = p-PSUM_LAT.
  - out_ready low: all three strobes are 0 and p holds. PE and buffer registers freeze, so array alignment is preserved. Stalls of any length are legal, including a stall at p=0.
- Boundaries:
  - num_vec=0 gives K=1: one weight read, one psum write at p=PSUM_LAT.
  - num_vec=2^VEC_W-1 gives K=2^VEC_W. The p counter is VEC_W+clog2(PSUM_LAT+1)+1 bits wide and must not wrap.
  - Addresses compare and truncate in unsigned arithmetic; weight_rd_addr and psum_wr_addr never exceed K-1.
- All outputs are combinational from state/counters/out_ready, except input_en, which is registered.

Decomposition:
- Package is_array_pkg holds the state enum (IDLE=0, LOAD=1, PROC=2, DONE=3) and clog2-derived width constants.
- One sub-module, is_ctrl_counter: an up-counter with enable, synchronous clear and terminal-count compare, used for both i and p.
- FSM and strobe decode live in the top.

Test Plan:
1. ROWS=4, PSUM_LAT=7, num_vec=2, start at cycle 0, out_ready=1 -> LOAD cycles 1-4, input_rd_addr 3,2,1,0; input_en high cycles 2-5; PROC cycles 5-14; weight_rd_en cycles 5-7 with addr 0,1,2; process_en cycles 6-14; psum_wr_en cycles 12-14 with addr 0,1,2; done only at cycle 15; busy cycles 1-15.
2. num_vec=0 -> exactly one weight read (addr 0) and one psum write (addr 0), at p=7; done 9 cycles after LOAD ends.
3. Config of test 1 with out_ready=0 for 3 cycles at p=8 -> process_en and psum_wr_en low for those 3 cycles; psum_wr_addr stays 1 after resume; done delayed by exactly 3 cycles.
4. rst_n asserted asynchronously mid-PROC at p=4 -> all outputs 0 immediately (before the next edge); after release, state is IDLE; a new start runs a clean full pass.
5. start held high through a whole pass and pulsed during PROC -> mid-pass pulses ignored; a second pass begins only from IDLE (the cycle after done).
6. num_vec=255 (VEC_W=8) -> 256 weight reads (addr 0..255) and 256 psum writes; no address wrap; p reaches 262.

Source files
------------

// File: rtl/is_array_pkg.sv
// rtl/is_array_pkg.sv - shared state encoding and width helpers for the input-stationary array sequencer
package is_array_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PROC = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int ROWS_DEF     = 4;
   localparam int COLS_DEF     = 4;
   localparam int VEC_W_DEF    = 8;
   localparam int PSUM_LAT_DEF = 7;

   // Address width that stays at least one bit for a single-row array.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Process counter must hold PSUM_LAT + 2^VEC_W - 1 without wrapping.
   function automatic int p_w(input int vec_w, input int lat);
      return vec_w + $clog2(lat + 1) + 1;
   endfunction

endpackage

// File: rtl/is_array_if.sv
// rtl/is_array_if.sv - command, buffer strobe and array enable bundle of the array sequencer
interface is_array_if #(
   parameter int ROWS  = 4,
   parameter int VEC_W = 8
);
   localparam int AW = is_array_pkg::addr_w(ROWS);

   logic             start;
   logic [VEC_W-1:0] num_vec;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             input_rd_en;
   logic [AW-1:0]    input_rd_addr;
   logic             input_en;
   logic             weight_rd_en;
   logic [VEC_W-1:0] weight_rd_addr;
   logic             process_en;
   logic             psum_wr_en;
   logic [VEC_W-1:0] psum_wr_addr;

   modport master (
      input  start, num_vec, out_ready,
      output busy, done, input_rd_en, input_rd_addr, input_en,
             weight_rd_en, weight_rd_addr, process_en, psum_wr_en, psum_wr_addr
   );

   modport slave (
      output start, num_vec, out_ready,
      input  busy, done, input_rd_en, input_rd_addr, input_en,
             weight_rd_en, weight_rd_addr, process_en, psum_wr_en, psum_wr_addr
   );

endinterface

// File: rtl/is_ctrl_counter.sv
// rtl/is_ctrl_counter.sv - up-counter with enable, synchronous clear and terminal-count compare
module is_ctrl_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic         at_last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign at_last = (count == last);

endmodule

// File: rtl/is_array_ctrl.sv
// rtl/is_array_ctrl.sv - LOAD/PROC sequencer driving buffer strobes and PE enables of a systolic array
module is_array_ctrl
   import is_array_pkg::*;
#(
   parameter int ROWS     = ROWS_DEF,
   parameter int COLS     = COLS_DEF,
   parameter int VEC_W    = VEC_W_DEF,
   parameter int PSUM_LAT = PSUM_LAT_DEF
) (
   input logic        clk,
   input logic        rst_n,
   is_array_if.master bus
);

   localparam int AW = addr_w(ROWS);
   localparam int PW = p_w(VEC_W, PSUM_LAT);

   if (COLS < 1 || PSUM_LAT < 1 || ROWS < 1) begin : g_bad_cfg
      $error("is_array_ctrl: ROWS, COLS and PSUM_LAT must all be at least 1");
   end

   state_t           state;
   logic [VEC_W-1:0] k_m1;
   logic             input_en_q;

   logic [AW-1:0]    i_cnt;
   logic             i_last;
   logic [PW-1:0]    p_cnt;
   logic             p_last;
   logic [PW-1:0]    p_final;

   logic             in_load;
   logic             in_proc;
   logic             w_win;
   logic             ps_win;

   assign in_load = (state == LOAD);
   assign in_proc = (state == PROC);
   assign p_final = PW'(PSUM_LAT) + PW'(k_m1);

   is_ctrl_counter #(.W(AW)) u_i_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (in_load),
      .clr     (!in_load),
      .last    (AW'(ROWS - 1)),
      .count   (i_cnt),
      .at_last (i_last)
   );

   // p freezes whenever the sink stalls so array alignment is kept.
   is_ctrl_counter #(.W(PW)) u_p_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (in_proc && bus.out_ready),
      .clr     (!in_proc),
      .last    (p_final),
      .count   (p_cnt),
      .at_last (p_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         k_m1       <= '0;
         input_en_q <= 1'b0;
      end else begin
         input_en_q <= in_load;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state <= LOAD;
                  k_m1  <= bus.num_vec;
               end
            end
            LOAD: begin
               if (i_last) begin
                  state <= PROC;
               end
            end
            PROC: begin
               if (p_last && bus.out_ready) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Address windows ignore out_ready so addresses hold steady through a stall.
   assign w_win  = in_proc && (p_cnt <= PW'(k_m1));
   assign ps_win = in_proc && (p_cnt >= PW'(PSUM_LAT)) && (p_cnt <= p_final);

   assign bus.busy           = (state != IDLE);
   assign bus.done           = (state == DONE);
   assign bus.input_rd_en    = in_load;
   assign bus.input_rd_addr  = in_load ? (AW'(ROWS - 1) - i_cnt) : '0;
   assign bus.input_en       = input_en_q;
   assign bus.weight_rd_en   = w_win && bus.out_ready;
   assign bus.weight_rd_addr = w_win ? VEC_W'(p_cnt) : '0;
   assign bus.process_en     = in_proc && (p_cnt != '0) && bus.out_ready;
   assign bus.psum_wr_en     = ps_win && bus.out_ready;
   assign bus.psum_wr_addr   = ps_win ? VEC_W'(p_cnt - PW'(PSUM_LAT)) : '0;

endmodule

// File: tb/tb_is_array_ctrl.sv
// tb/tb_is_array_ctrl.sv - scoreboard bench for the input-stationary array sequencer
module tb_is_array_ctrl;

   typedef struct {
      int cyc;
      int addr;
   } ev_t;

   // kinds: 0 input_rd, 1 input_en, 2 weight_rd, 3 process_en, 4 psum_wr, 5 done, 6 busy
   ev_t sbq [7][$];

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   is_array_if #(.ROWS(4), .VEC_W(8)) bus ();

   is_array_ctrl #(.ROWS(4), .COLS(4), .VEC_W(8), .PSUM_LAT(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int kind, input int c, input int a);
      ev_t e;
      e.cyc  = c;
      e.addr = a;
      sbq[kind].push_back(e);
   endtask

   // Expected timeline for ROWS=4, PSUM_LAT=7 with start sampled at the end of cycle c0.
   task automatic exp_pass(input int c0, input int k, input int sp, input int sl, output int dcyc);
      int c;
      for (int i = 0; i < 4; i++) begin
         push(0, c0 + 1 + i, 3 - i);
         push(1, c0 + 2 + i, 0);
      end
      c = c0 + 5;
      for (int p = 0; p <= 6 + k; p++) begin
         if (p == sp) c += sl;
         if (p < k) push(2, c, p);
         if (p >= 1) push(3, c, 0);
         if (p >= 7) push(4, c, p - 7);
         c++;
      end
      push(5, c, 0);
      for (int b = c0 + 1; b <= c; b++) push(6, b, 0);
      dcyc = c;
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_empty(input string tag);
      for (int k = 0; k < 7; k++) chk($sformatf("%s_left_kind%0d", tag, k), sbq[k].size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
      chk({tag, "_in_rd"}, int'(bus.input_rd_en), 0);
      chk({tag, "_in_addr"}, int'(bus.input_rd_addr), 0);
      chk({tag, "_in_en"}, int'(bus.input_en), 0);
      chk({tag, "_w_rd"}, int'(bus.weight_rd_en), 0);
      chk({tag, "_w_addr"}, int'(bus.weight_rd_addr), 0);
      chk({tag, "_proc"}, int'(bus.process_en), 0);
      chk({tag, "_ps_wr"}, int'(bus.psum_wr_en), 0);
      chk({tag, "_ps_addr"}, int'(bus.psum_wr_addr), 0);
   endtask

   always @(negedge clk) begin : monitor
      logic [6:0] s;
      int         a [7];
      ev_t        e;
      s = {bus.busy, bus.done, bus.psum_wr_en, bus.process_en,
           bus.weight_rd_en, bus.input_en, bus.input_rd_en};
      a[0] = int'(bus.input_rd_addr);
      a[1] = 0;
      a[2] = int'(bus.weight_rd_addr);
      a[3] = 0;
      a[4] = int'(bus.psum_wr_addr);
      a[5] = 0;
      a[6] = 0;
      for (int k = 0; k < 7; k++) begin
         if (s[k]) begin
            total++;
            if (sbq[k].size() == 0) begin
               bad++;
               $display("FAIL unexpected_kind%0d at cycle %0d addr %0d, want no strobe", k, cyc, a[k]);
            end else begin
               e = sbq[k].pop_front();
               if (e.cyc != cyc || e.addr != a[k]) begin
                  bad++;
                  $display("FAIL event_kind%0d: got cycle %0d addr %0d, want cycle %0d addr %0d",
                           k, cyc, a[k], e.cyc, e.addr);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, d1, d2;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.num_vec   = '0;
      bus.out_ready = 1'b1;
      #2;
      check_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      goto(cyc + 2);

      // 1: K=3, no stalls
      c0 = cyc;
      bus.start   = 1'b1;
      bus.num_vec = 8'd2;
      exp_pass(c0, 3, -1, 0, d1);
      goto(c0 + 1);
      bus.start = 1'b0;
      goto(d1 + 2);
      check_empty("t1");

      // 2: K=1
      c0 = cyc;
      bus.start   = 1'b1;
      bus.num_vec = 8'd0;
      exp_pass(c0, 1, -1, 0, d1);
      chk("t2_done_after_load", d1 - (c0 + 4), 9);
      goto(c0 + 1);
      bus.start = 1'b0;
      goto(d1 + 2);
      check_empty("t2");

      // 3: K=3, sink stalls 3 cycles at p=8
      c0 = cyc;
      bus.start   = 1'b1;
      bus.num_vec = 8'd2;
      exp_pass(c0, 3, 8, 3, d1);
      chk("t3_done_cycle", d1 - c0, 18);
      goto(c0 + 1);
      bus.start = 1'b0;
      for (int j = 0; j < 3; j++) begin
         goto(c0 + 13 + j);
         bus.out_ready = 1'b0;
         #1;
         chk("t3_stall_ps_addr", int'(bus.psum_wr_addr), 1);
         chk("t3_stall_ps_wr", int'(bus.psum_wr_en), 0);
         chk("t3_stall_proc", int'(bus.process_en), 0);
      end
      goto(c0 + 16);
      bus.out_ready = 1'b1;
      goto(d1 + 2);
      check_empty("t3");

      // 4: asynchronous reset at p=4, then a clean pass
      c0 = cyc;
      bus.start   = 1'b1;
      bus.num_vec = 8'd2;
      exp_pass(c0, 3, -1, 0, d1);
      goto(c0 + 1);
      bus.start = 1'b0;
      goto(c0 + 9);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("t4_async");
      for (int k = 0; k < 7; k++) sbq[k].delete();
      goto(cyc + 2);
      rst_n = 1'b1;
      chk("t4_idle_busy", int'(bus.busy), 0);
      goto(cyc + 1);
      c0 = cyc;
      bus.start = 1'b1;
      exp_pass(c0, 3, -1, 0, d1);
      goto(c0 + 1);
      bus.start = 1'b0;
      goto(d1 + 2);
      check_empty("t4");

      // 5: start held through a pass, then pulsed mid-PROC
      c0 = cyc;
      bus.start   = 1'b1;
      bus.num_vec = 8'd1;
      exp_pass(c0, 2, -1, 0, d1);
      exp_pass(d1 + 1, 2, -1, 0, d2);
      goto(d1 + 11);
      bus.start = 1'b0;
      goto(d1 + 13);
      bus.start = 1'b1;
      goto(d1 + 14);
      bus.start = 1'b0;
      goto(d2 + 3);
      check_empty("t5");

      // 6: K=256, no address wrap
      c0 = cyc;
      bus.start   = 1'b1;
      bus.num_vec = 8'd255;
      exp_pass(c0, 256, -1, 0, d1);
      chk("t6_done_cycle", d1 - c0, 5 + 263);
      goto(c0 + 1);
      bus.start = 1'b0;
      goto(d1 + 2);
      check_empty("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
